mix_column_engine: RTL

Sequential, parametrised MixColumns/InvMixColumns engine with fused AddRoundKey, replacing the single-cycle combinational MixColumn in the AES round datapath. It processes COLS_PER_CYCLE 32-bit columns per clock behind valid/ready handshakes on both sides. The round controller trades area against latency through the parameter. Encrypt computes MixColumns(state) ^ key; decrypt computes InvMixColumns(state ^ key).

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/mix_single_column.sv | 32 +++
 rtl/mix_column_engine.sv | 113 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - GF(2^8) helpers and FSM encodings for the MixColumns engine
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_RUN  = 2'd1;
    localparam logic [1:0] ENC_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ENC_IDLE,
        RUN  = ENC_RUN,
        DONE = ENC_DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// rtl/mix_single_column.sv - combinational MixColumns / InvMixColumns of one 32-bit column
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        dec,
    output logic [31:0] col_out
);

    // Every output row is the first matrix row applied to a rotated column.
    function automatic logic [7:0] mix_row(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3,
                                           input logic inv);
        if (inv)
            return gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
        else
            return gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
    endfunction

    logic [7:0] b0, b1, b2, b3;

    assign b0 = col_in[31:24];
    assign b1 = col_in[23:16];
    assign b2 = col_in[15:8];
    assign b3 = col_in[7:0];

    assign col_out = {mix_row(b0, b1, b2, b3, dec),
                      mix_row(b1, b2, b3, b0, dec),
                      mix_row(b2, b3, b0, b1, dec),
                      mix_row(b3, b0, b1, b2, dec)};

endmodule

// File: rtl/mix_column_engine.sv
// rtl/mix_column_engine.sv - sequential MixColumns/InvMixColumns with fused AddRoundKey
module mix_column_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit ADD_KEY        = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         dec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int         N    = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST = 2'(N - 1);

    state_t              state;
    logic [1:0]          cnt;
    logic                dec_q;
    logic [0:3][31:0]    st_q;
    logic [0:3][31:0]    key_q;
    logic [0:3][31:0]    key_eff;
    logic [0:3][31:0]    acc_q;
    logic [0:3][31:0]    acc_next;
    logic [0:3][31:0]    out_q;
    logic [1:0]          base;
    logic                accept;

    logic [1:0]          col_idx [COLS_PER_CYCLE];
    logic [31:0]         col_r   [COLS_PER_CYCLE];

    assign key_eff   = ADD_KEY ? key_q : '0;
    assign base      = cnt * 2'(COLS_PER_CYCLE);
    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign out_state = out_q;

    // Key goes in before the inverse transform and after the forward one.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        logic [31:0] col_x;
        logic [31:0] col_y;

        assign col_idx[g] = base + 2'(g);
        assign col_x      = dec_q ? (st_q[col_idx[g]] ^ key_eff[col_idx[g]]) : st_q[col_idx[g]];
        assign col_r[g]   = dec_q ? col_y : (col_y ^ key_eff[col_idx[g]]);

        mix_single_column u_mix (
            .col_in  (col_x),
            .dec     (dec_q),
            .col_out (col_y)
        );
    end

    always_comb begin
        acc_next = acc_q;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            acc_next[col_idx[g]] = col_r[g];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dec_q <= 1'b0;
            st_q  <= '0;
            key_q <= '0;
            acc_q <= '0;
            out_q <= '0;
        end else begin
            case (state)
                IDLE: ;
                RUN: begin
                    acc_q <= acc_next;
                    if (cnt == LAST) begin
                        out_q <= acc_next;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A retiring DONE and a fresh capture can share the same edge.
            if (accept) begin
                st_q  <= in_state;
                key_q <= in_key;
                dec_q <= dec;
                cnt   <= '0;
                state <= RUN;
            end
        end
    end

endmodule
